// File: rtl/rotating_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : rotating_dispatch
// Brief    : Ring of PAIR_NUM carts that distributes a tagged serial word
//            stream to per-tag pair channels, recirculating on busy channels.
//            Optional counters under `ROTATING_DISPATCH_STATS_EN`.
// Revision : 1.0 - initial release
// ============================================================================
module rotating_dispatch #(
  parameter int PAIR_DATA_WIDTH = 20,
  parameter int PAIR_WIDTH      = 8,
  parameter int PAIR_NUM        = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PAIR_DATA_WIDTH-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [PAIR_DATA_WIDTH-1:0] pair_data_out [PAIR_NUM-1:0],
  output logic [PAIR_NUM-1:0]        pair_data_out_en,
  input  logic [PAIR_NUM-1:0]        pair_data_ready,
  output logic                       tag_err
`ifdef ROTATING_DISPATCH_STATS_EN
  ,
  output logic [31:0]                inject_count,
  output logic [31:0]                deliver_count,
  output logic [31:0]                recirc_count
`endif
);

  localparam int c_tag_lsb = PAIR_DATA_WIDTH - PAIR_WIDTH;

  logic [PAIR_NUM-1:0]        r_cart_valid;
  logic [PAIR_DATA_WIDTH-1:0] r_cart_data [PAIR_NUM-1:0];

  logic [PAIR_NUM-1:0] w_hit;
  logic                w_recirc;
  logic                w_accept;
  logic                w_in_tag_ok;
  logic                w_inject;

  // A cart delivers when it sits at the index equal to its own tag.
  for (genvar gi = 0; gi < PAIR_NUM; gi++) begin : g_hit
    assign w_hit[gi] = r_cart_valid[gi]
                    && (r_cart_data[gi][PAIR_DATA_WIDTH-1:c_tag_lsb] == PAIR_WIDTH'(gi))
                    && pair_data_ready[gi];
  end

  assign w_recirc    = r_cart_valid[0] && !w_hit[0];
  assign in_ready    = !w_recirc;
  assign w_accept    = in_valid && in_ready;
  assign w_in_tag_ok = ({1'b0, in_data[PAIR_DATA_WIDTH-1:c_tag_lsb]} < (PAIR_WIDTH+1)'(PAIR_NUM));
  assign w_inject    = w_accept && w_in_tag_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cart_valid <= '0;
      for (int i = 0; i < PAIR_NUM; i++) begin
        r_cart_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < PAIR_NUM - 1; i++) begin
        r_cart_valid[i] <= r_cart_valid[i+1] && !w_hit[i+1];
        r_cart_data[i]  <= r_cart_data[i+1];
      end
      // Recirculation owns the wrap slot; injection only fills a free slot.
      if (w_recirc) begin
        r_cart_valid[PAIR_NUM-1] <= 1'b1;
        r_cart_data[PAIR_NUM-1]  <= r_cart_data[0];
      end else if (w_inject) begin
        r_cart_valid[PAIR_NUM-1] <= 1'b1;
        r_cart_data[PAIR_NUM-1]  <= in_data;
      end else begin
        r_cart_valid[PAIR_NUM-1] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_data_out_en <= '0;
      tag_err          <= 1'b0;
      for (int i = 0; i < PAIR_NUM; i++) begin
        pair_data_out[i] <= '0;
      end
    end else begin
      pair_data_out_en <= w_hit;
      tag_err          <= w_accept && !w_in_tag_ok;
      for (int i = 0; i < PAIR_NUM; i++) begin
        if (w_hit[i]) begin
          pair_data_out[i] <= r_cart_data[i];
        end
      end
    end
  end

`ifdef ROTATING_DISPATCH_STATS_EN
  logic [31:0] w_en_pop;

  always_comb begin
    w_en_pop = '0;
    for (int i = 0; i < PAIR_NUM; i++) begin
      w_en_pop = w_en_pop + 32'(pair_data_out_en[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inject_count  <= '0;
      deliver_count <= '0;
      recirc_count  <= '0;
    end else begin
      inject_count  <= inject_count + 32'(w_inject);
      deliver_count <= deliver_count + w_en_pop;
      recirc_count  <= recirc_count + 32'(w_recirc);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rotating_dispatch.sv
// Bench for rotating_dispatch: queue-based word model checked every cycle,
// plus hand-computed latency, recirculation, bad-tag and reset expectations.
`timescale 1ns/1ps
`default_nettype none
module tb_rotating_dispatch;

  localparam int W  = 12;
  localparam int PW = 3;
  localparam int N  = 8;
  localparam int N6 = 6;

  typedef struct {
    logic [W-1:0] data;
    int           pos;
  } word_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  pout [N-1:0];
  logic [N-1:0]  pen;
  logic [N-1:0]  pready;
  logic          tag_err;

  logic [W-1:0]  in6_data;
  logic          in6_valid;
  logic          in6_ready;
  logic [W-1:0]  pout6 [N6-1:0];
  logic [N6-1:0] pen6;
  logic [N6-1:0] pready6;
  logic          tag_err6;

`ifdef ROTATING_DISPATCH_STATS_EN
  logic [31:0] inj_cnt, del_cnt, rec_cnt;
  logic [31:0] inj6_cnt, del6_cnt, rec6_cnt;
`endif

  rotating_dispatch #(.PAIR_DATA_WIDTH(W), .PAIR_WIDTH(PW), .PAIR_NUM(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .pair_data_out(pout), .pair_data_out_en(pen),
    .pair_data_ready(pready), .tag_err(tag_err)
`ifdef ROTATING_DISPATCH_STATS_EN
    , .inject_count(inj_cnt), .deliver_count(del_cnt), .recirc_count(rec_cnt)
`endif
  );

  rotating_dispatch #(.PAIR_DATA_WIDTH(W), .PAIR_WIDTH(PW), .PAIR_NUM(N6)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_data(in6_data), .in_valid(in6_valid),
    .in_ready(in6_ready), .pair_data_out(pout6), .pair_data_out_en(pen6),
    .pair_data_ready(pready6), .tag_err(tag_err6)
`ifdef ROTATING_DISPATCH_STATS_EN
    , .inject_count(inj6_cnt), .deliver_count(del6_cnt), .recirc_count(rec6_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int tagof(input logic [W-1:0] d);
    return int'(d[W-1 -: PW]);
  endfunction

  // Model: in-flight words with their current ring position.
  word_t        q[$];
  word_t        nq[$];
  logic [N-1:0] exp_en;
  logic [W-1:0] exp_out [N];
  logic         exp_terr;
  int           m_inj, m_del, m_rec;

  initial begin : p_check
    word_t w;
    int    t;
    logic  m_ready;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        exp_en   = '0;
        exp_terr = 1'b0;
        for (int i = 0; i < N; i++) exp_out[i] = '0;
        m_inj = 0; m_del = 0; m_rec = 0;
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_en", 32'(pen), 32'h0);
        chk("rst_tag_err", 32'(tag_err), 32'h0);
        for (int i = 0; i < N; i++) chk($sformatf("rst_out%0d", i), 32'(pout[i]), 32'h0);
      end else begin
        m_ready = 1'b1;
        foreach (q[j]) begin
          if (q[j].pos == 0 && !(tagof(q[j].data) == 0 && pready[0])) m_ready = 1'b0;
        end
        chk("in_ready", 32'(in_ready), 32'(m_ready));
        chk("en", 32'(pen), 32'(exp_en));
        chk("tag_err", 32'(tag_err), 32'(exp_terr));
        for (int i = 0; i < N; i++) chk($sformatf("out%0d", i), 32'(pout[i]), 32'(exp_out[i]));
`ifdef ROTATING_DISPATCH_STATS_EN
        chk("inject_count", inj_cnt, 32'(m_inj));
        chk("deliver_count", del_cnt, 32'(m_del));
        chk("recirc_count", rec_cnt, 32'(m_rec));
`endif
        // Advance the model to the state after the coming posedge.
        exp_terr = 1'b0;
        m_del += $countones(exp_en);
        exp_en = '0;
        nq.delete();
        foreach (q[j]) begin
          w = q[j];
          t = tagof(w.data);
          if (w.pos == t && pready[t]) begin
            exp_en[t]  = 1'b1;
            exp_out[t] = w.data;
          end else begin
            if (w.pos == 0) begin
              w.pos = N - 1;
              m_rec++;
            end else begin
              w.pos--;
            end
            nq.push_back(w);
          end
        end
        if (in_valid && m_ready) begin
          if (tagof(in_data) < N) begin
            w.data = in_data;
            w.pos  = N - 1;
            nq.push_back(w);
            m_inj++;
          end else begin
            exp_terr = 1'b1;
          end
        end
        q = nq;
      end
    end
  end

  task automatic send(input logic [W-1:0] d);
    @(posedge clk); #2;
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic expect_hit(input string name, input int ch, input logic [W-1:0] d, input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    chk({name, "_en"}, 32'(pen[ch]), 32'h1);
    chk({name, "_data"}, 32'(pout[ch]), 32'(d));
  endtask

  initial begin : p_stim
    in_valid  = 1'b0;
    in_data   = '0;
    pready    = '1;
    in6_valid = 1'b0;
    in6_data  = '0;
    pready6   = '1;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk); #2;
    rst_n = 1'b1;

    // Latency: tag t arrives N-t edges after acceptance.
    send(12'hEA5);
    expect_hit("lat_t7", 7, 12'hEA5, 1);
    send(12'h0C3);
    expect_hit("lat_t0", 0, 12'h0C3, 8);
    send(12'h7A5);
    expect_hit("lat_t3", 3, 12'h7A5, 5);

    // Burst of tags 0..7 on consecutive edges: all land on the same edge.
    @(posedge clk); #2;
    for (int t = 0; t < N; t++) begin
      in_valid = 1'b1;
      in_data  = {3'(t), 9'(t)};
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("burst_en", 32'(pen), 32'hFF);
    chk("burst_out3", 32'(pout[3]), 32'h603);
    chk("burst_out7", 32'(pout[7]), 32'hE07);
    repeat (10) @(posedge clk);

    // Recirculation past a blocked channel 2.
    #2 rst_n = 1'b0;
    pready[2] = 1'b0;
    repeat (2) @(posedge clk); #2;
    rst_n = 1'b1;
    send(12'h4FF);
    repeat (7) @(posedge clk); #2;
    in_valid = 1'b1;
    in_data  = 12'h6AA;
    @(negedge clk);
    chk("recirc_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk); #2;
    in_valid  = 1'b0;
    pready[2] = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("recirc_en2", 32'(pen[2]), 32'h1);
    chk("recirc_out2", 32'(pout[2]), 32'h4FF);
    repeat (4) @(posedge clk);
    @(negedge clk);
`ifdef ROTATING_DISPATCH_STATS_EN
    chk("stats_inject", inj_cnt, 32'd1);
    chk("stats_deliver", del_cnt, 32'd1);
    chk("stats_recirc", rec_cnt, 32'd1);
`endif

    // Six-channel ring: tags 6 and 7 are rejected, tag 5 delivers next edge.
    @(posedge clk); #2;
    in6_data  = 12'hE12;
    in6_valid = 1'b1;
    @(negedge clk);
    chk("bad_in_ready", 32'(in6_ready), 32'h1);
    @(posedge clk); #2;
    in6_valid = 1'b0;
    @(negedge clk);
    chk("bad_tag_err", 32'(tag_err6), 32'h1);
    chk("bad_en", 32'(pen6), 32'h0);
    @(negedge clk);
    chk("bad_tag_err_drop", 32'(tag_err6), 32'h0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("bad_no_en", 32'(pen6), 32'h0);
      chk("bad_ready", 32'(in6_ready), 32'h1);
    end
    @(posedge clk); #2;
    in6_data  = 12'hA11;
    in6_valid = 1'b1;
    @(posedge clk); #2;
    in6_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("n6_t5_en", 32'(pen6), 32'h20);
    chk("n6_t5_out", 32'(pout6[5]), 32'hA11);

    // Mid-flight reset with channel 5 blocked.
    pready[5] = 1'b0;
    @(posedge clk); #2;
    for (int j = 1; j <= 4; j++) begin
      in_valid = 1'b1;
      in_data  = 12'hA00 + 12'(j);
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en", 32'(pen), 32'h0);
    chk("mid_rst_tag_err", 32'(tag_err), 32'h0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'h1);
    for (int i = 0; i < N; i++) chk($sformatf("mid_rst_out%0d", i), 32'(pout[i]), 32'h0);
    repeat (2) @(posedge clk); #2;
    rst_n     = 1'b1;
    pready[5] = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("no_stale_en", 32'(pen), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
